// File: rtl/memory_timing_pkg.sv
// Shared timing constants and state encoding for the mercury-tank controllers.
// Contents: tank geometry (pulse positions per minor cycle, word lengths,
// slots per circulation) and the access-sequencer state enum.
package memory_timing_pkg;

  localparam int BITS_PER_MINOR = 18;
  localparam int DATA_BITS      = 17;
  localparam int LONG_BITS      = 35;
  localparam int SLOTS          = 32;
  localparam int ADDR_W         = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } tank_state_e;

endpackage

// File: rtl/memory_tank_access_ctrl_if.sv
// Request/response bus between the store's address/order logic and a tank
// access controller.
//   req/req_we/req_long/req_addr/req_wdata : request, held until ack
//   ack                                    : one-cycle completion pulse
//   rdata                                  : read result (LSB = first bit)
//   busy                                   : operation in progress
// master = requester side, slave = controller side.
interface memory_tank_access_ctrl_if #(
  parameter int ADDR_W = memory_timing_pkg::ADDR_W
);
  import memory_timing_pkg::*;

  logic                 req;
  logic                 req_we;
  logic                 req_long;
  logic [ADDR_W-1:0]    req_addr;
  logic [LONG_BITS-1:0] req_wdata;
  logic                 ack;
  logic [LONG_BITS-1:0] rdata;
  logic                 busy;

  modport master (
    output req, req_we, req_long, req_addr, req_wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, req_we, req_long, req_addr, req_wdata,
    output ack, rdata, busy
  );

endinterface

// File: rtl/memory_timing_counter.sv
// Free-running minor-cycle position counter for one delay-line tank.
// A counter value (slot, bit_pos) means the tank output currently carries
// bit bit_pos of word slot. bit_pos runs 0..BITS_PER_MINOR-1, slot advances
// on the bit_pos wrap and wraps after SLOTS words.
//   clk, rst_n  : bit-time clock, asynchronous active-low reset
//   slot        : current word (minor cycle) number
//   slot_start  : high while bit_pos == 0
module memory_timing_counter #(
  parameter int BITS_PER_MINOR = memory_timing_pkg::BITS_PER_MINOR,
  parameter int SLOTS          = memory_timing_pkg::SLOTS,
  parameter int ADDR_W         = memory_timing_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] slot,
  output logic              slot_start
);

  localparam int                  POS_W     = $clog2(BITS_PER_MINOR);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(BITS_PER_MINOR - 1);
  localparam logic [ADDR_W-1:0]   SLOT_LAST = ADDR_W'(SLOTS - 1);

  logic [POS_W-1:0] bit_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_pos <= '0;
      slot    <= '0;
    end else if (bit_pos == POS_LAST) begin
      bit_pos <= '0;
      slot    <= (slot == SLOT_LAST) ? '0 : slot + ADDR_W'(1);
    end else begin
      bit_pos <= bit_pos + POS_W'(1);
    end
  end

  assign slot_start = (bit_pos == '0);

endmodule

// File: rtl/memory_tank_access_ctrl.sv
// Access sequencer for one 32-word mercury delay-line tank.
// Accepts one short (17-bit) or long (35-bit, even slot pair) read/write,
// waits for the addressed word to come round, then drives the tank gates
// and serialises (write) or deserialises (read) the word LSB first.
//   r2_clk, r2_rst_n : bit-time clock, asynchronous active-low reset
//   bus (slave)      : request/ack/rdata/busy handshake
//   tank_mob         : serial bit leaving the tank
//   tank_mib         : serial bit inserted into the tank
//   tank_clr         : break recirculation at the current bit
//   tank_in          : gate tank_mib into the tank
//   tank_out         : read gate toward the tank output
//   monitor_slot     : current slot counter for the monitor CRT
module memory_tank_access_ctrl #(
  parameter int BITS_PER_MINOR = memory_timing_pkg::BITS_PER_MINOR,
  parameter int SLOTS          = memory_timing_pkg::SLOTS,
  parameter int ADDR_W         = memory_timing_pkg::ADDR_W
) (
  input  logic                            r2_clk,
  input  logic                            r2_rst_n,
  memory_tank_access_ctrl_if.slave        bus,
  input  logic                            tank_mob,
  output logic                            tank_mib,
  output logic                            tank_clr,
  output logic                            tank_in,
  output logic                            tank_out,
  output logic [ADDR_W-1:0]               monitor_slot
);
  import memory_timing_pkg::*;

  localparam int             K_W          = $clog2(LONG_BITS);
  localparam logic [K_W-1:0] K_LAST_SHORT = K_W'(DATA_BITS - 1);
  localparam logic [K_W-1:0] K_LAST_LONG  = K_W'(LONG_BITS - 1);

  tank_state_e          state, state_nxt;
  logic [K_W-1:0]       k_q, k_cur;
  logic                 we_q, long_q;
  logic [ADDR_W-1:0]    eff_q;
  logic [LONG_BITS-1:0] wdata_q, rbuf_q, rbuf_nxt, rdata_q;
  logic [ADDR_W-1:0]    slot;
  logic                 slot_start, start_hit, xfer_act, last_bit;

  memory_timing_counter #(
    .BITS_PER_MINOR (BITS_PER_MINOR),
    .SLOTS          (SLOTS),
    .ADDR_W         (ADDR_W)
  ) u_timing (
    .clk        (r2_clk),
    .rst_n      (r2_rst_n),
    .slot       (slot),
    .slot_start (slot_start)
  );

  // Bit 0 of a transfer is moved while still in WAIT, on the cycle the
  // addressed word reaches the output; XFER then covers bits 1..N-1. This
  // keeps the gates aligned to the counter without a look-ahead compare.
  assign start_hit = (state == WAIT) && slot_start && (slot == eff_q);
  assign xfer_act  = start_hit || (state == XFER);
  assign k_cur     = (state == XFER) ? k_q : '0;
  assign last_bit  = (state == XFER) &&
                     (k_q == (long_q ? K_LAST_LONG : K_LAST_SHORT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req)   state_nxt = WAIT;
      WAIT:    if (start_hit) state_nxt = XFER;
      XFER:    if (last_bit)  state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rbuf_nxt = rbuf_q;
    if (xfer_act && !we_q) rbuf_nxt[k_cur] = tank_mob;
  end

  // Control stage: state, bit index and the held read result.
  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      state   <= IDLE;
      k_q     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_hit) begin
        k_q <= K_W'(1);
      end else if (state == XFER) begin
        k_q <= k_q + K_W'(1);
      end
      // Final sampled bit is merged so rdata is complete on the ack cycle.
      if (last_bit && !we_q) rdata_q <= rbuf_nxt;
    end
  end

  // Request capture and read assembly; later req_* changes are ignored.
  always_ff @(posedge r2_clk) begin
    if (state == IDLE && bus.req) begin
      we_q    <= bus.req_we;
      long_q  <= bus.req_long;
      eff_q   <= bus.req_long ? {bus.req_addr[ADDR_W-1:1], 1'b0} : bus.req_addr;
      wdata_q <= bus.req_wdata;
      rbuf_q  <= '0;
    end else begin
      rbuf_q  <= rbuf_nxt;
    end
  end

  assign tank_clr     = xfer_act && we_q;
  assign tank_in      = xfer_act && we_q;
  assign tank_mib     = xfer_act && we_q && wdata_q[k_cur];
  assign tank_out     = xfer_act && !we_q;
  assign bus.ack      = (state == DONE);
  assign bus.busy     = (state == WAIT) || (state == XFER);
  assign bus.rdata    = rdata_q;
  assign monitor_slot = slot;

endmodule

// File: tb/tb_memory_tank_access_ctrl.sv
// Directed bench for memory_tank_access_ctrl with a behavioural 576-bit tank.
module tb_memory_tank_access_ctrl;

  localparam logic [575:0] INIT_LINE = {18{32'h5A5A_8F8F}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tank_mob, tank_mib, tank_clr, tank_in, tank_out;
  logic [4:0] monitor_slot;

  memory_tank_access_ctrl_if #(.ADDR_W(5)) bus ();

  memory_tank_access_ctrl dut (
    .r2_clk       (clk),
    .r2_rst_n     (rst_n),
    .bus          (bus),
    .tank_mob     (tank_mob),
    .tank_mib     (tank_mib),
    .tank_clr     (tank_clr),
    .tank_in      (tank_in),
    .tank_out     (tank_out),
    .monitor_slot (monitor_slot)
  );

  always #5 clk = ~clk;

  // Behavioural tank: position index follows the bench's own counter.
  int           tb_pos;
  int           cyc = 0;
  logic [575:0] line = INIT_LINE;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_pos <= 0;
    else        tb_pos <= (tb_pos == 575) ? 0 : tb_pos + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tank_clr) line[tb_pos] <= tank_in ? tank_mib : 1'b0;
  end

  assign tank_mob = line[tb_pos];

  // Activity monitor, sampled mid-cycle.
  int   gate_total = 0, clr_total = 0, out_total = 0, ack_total = 0;
  int   act_first_cyc = 0, act_first_pos = 0, act_last_pos = 0;
  int   ack_cyc = 0, ack_pos = 0;
  logic act_prev = 1'b0;

  always @(negedge clk) begin
    if ((tank_in || tank_out) && !act_prev) begin
      act_first_cyc = cyc;
      act_first_pos = tb_pos;
    end
    if (tank_in || tank_out) act_last_pos = tb_pos;
    act_prev = tank_in || tank_out;
    if (tank_in)  gate_total++;
    if (tank_clr) clr_total++;
    if (tank_out) out_total++;
    if (bus.ack) begin
      ack_total++;
      ack_cyc = cyc;
      ack_pos = tb_pos;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 700; i++) begin
      if (tb_pos == p) return;
      tick(1);
    end
    $display("FAIL wait_pos: position %0d never reached (at %0d)", p, tb_pos);
    $fatal(1, "position wait expired");
  endtask

  // Issue at the start of an IDLE cycle, hold req until ack, drop it on ack.
  task automatic do_req(input logic we, input logic lng, input logic [4:0] addr,
                        input logic [34:0] wdata, output int cap, output logic got);
    bus.req       = 1'b1;
    bus.req_we    = we;
    bus.req_long  = lng;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    cap = cyc;
    got = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        got = 1'b1;
        break;
      end
    end
    bus.req = 1'b0;
    tick(1);
  endtask

  function automatic logic [34:0] exp_word(input int base, input int n);
    logic [575:0] v;
    logic [34:0]  w;
    v = INIT_LINE;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = v[base + i];
    return w;
  endfunction

  int   cap, g0, c0, o0, a0;
  logic got;

  initial begin
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_long = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    tick(3);
    check("rst_slot",  64'(monitor_slot), 64'd0);
    check("rst_ack",   64'(bus.ack), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_gates", 64'({tank_mib, tank_clr, tank_in, tank_out}), 64'd0);

    // Counter cadence and wrap
    rst_n = 1'b1;
    tick(18);
    check("slot_after_18", 64'(monitor_slot), 64'd1);
    tick(557);
    check("slot_after_575", 64'(monitor_slot), 64'd31);
    tick(1);
    check("slot_wrap_576", 64'(monitor_slot), 64'd0);

    // Reset mid-run
    tick(40);
    rst_n = 1'b0;
    #1;
    check("midrst_slot", 64'(monitor_slot), 64'd0);
    tick(2);
    rst_n = 1'b1;

    // Short write addr 5 issued at (3,4)
    wait_pos(3 * 18 + 4);
    g0 = gate_total; c0 = clr_total;
    do_req(1'b1, 1'b0, 5'd5, 35'h1ABCD, cap, got);
    check("sw_ack_seen",   64'(got), 64'd1);
    check("sw_first_pos",  64'(act_first_pos), 64'd90);
    check("sw_first_cyc",  64'(act_first_cyc - cap), 64'd32);
    check("sw_last_pos",   64'(act_last_pos), 64'd106);
    check("sw_gate_cnt",   64'(gate_total - g0), 64'd17);
    check("sw_clr_cnt",    64'(clr_total - c0), 64'd17);
    check("sw_ack_pos",    64'(ack_pos), 64'd107);
    check("sw_ack_lat",    64'(ack_cyc - act_first_cyc), 64'd17);
    check("sw_sandwich",   64'(line[107]), 64'd1);

    // Short read addr 5
    c0 = clr_total; o0 = out_total;
    do_req(1'b0, 1'b0, 5'd5, 35'h7_FFFF_FFFF, cap, got);
    check("sr_ack_seen", 64'(got), 64'd1);
    check("sr_rdata",    64'(bus.rdata), 64'h1ABCD);
    check("sr_clr_cnt",  64'(clr_total - c0), 64'd0);
    check("sr_out_cnt",  64'(out_total - o0), 64'd17);

    // Long write, addr 7 becomes 6
    g0 = gate_total;
    do_req(1'b1, 1'b1, 5'd7, 35'h5_5555_AAAA, cap, got);
    check("lw_ack_seen",  64'(got), 64'd1);
    check("lw_first_pos", 64'(act_first_pos), 64'd108);
    check("lw_last_pos",  64'(act_last_pos), 64'd142);
    check("lw_gate_cnt",  64'(gate_total - g0), 64'd35);
    check("lw_ack_pos",   64'(ack_pos), 64'd143);
    check("lw_next17",    64'(line[143]), 64'd1);

    // Long readback
    o0 = out_total;
    do_req(1'b0, 1'b1, 5'd7, 35'h0, cap, got);
    check("lr_ack_seen", 64'(got), 64'd1);
    check("lr_rdata",    64'(bus.rdata), 64'h5_5555_AAAA);
    check("lr_out_cnt",  64'(out_total - o0), 64'd35);

    // Worst-case wait: captured at (9,0) for slot 9
    wait_pos(9 * 18);
    do_req(1'b0, 1'b0, 5'd9, 35'h0, cap, got);
    check("wc_ack_seen", 64'(got), 64'd1);
    check("wc_start",    64'(act_first_cyc - cap), 64'd576);
    check("wc_ack",      64'(ack_cyc - cap), 64'd593);
    check("wc_rdata",    64'(bus.rdata), 64'(exp_word(162, 17)));

    // Immediate start: captured at (11,17) for slot 12
    wait_pos(11 * 18 + 17);
    do_req(1'b1, 1'b0, 5'd12, 35'h0F0F3, cap, got);
    check("im_ack_seen", 64'(got), 64'd1);
    check("im_start",    64'(act_first_cyc - cap), 64'd1);
    check("im_first_pos", 64'(act_first_pos), 64'd216);
    check("im_ack",      64'(ack_cyc - act_first_cyc), 64'd17);
    do_req(1'b0, 1'b0, 5'd12, 35'h0, cap, got);
    check("im_rdata",    64'(bus.rdata), 64'h0F0F3);

    // Abort: reset during write of slot 2 at transfer bit 8
    wait_pos(20);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_long = 1'b0;
    bus.req_addr = 5'd2; bus.req_wdata = 35'h1FFFF;
    tick(1);
    check("ab_busy", 64'(bus.busy), 64'd1);
    wait_pos(2 * 18 + 8);
    check("ab_gate_bit8", 64'(tank_in), 64'd1);
    a0 = ack_total;
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check("ab_gates",  64'({tank_mib, tank_clr, tank_in, tank_out}), 64'd0);
    check("ab_busy0",  64'(bus.busy), 64'd0);
    check("ab_rdata0", 64'(bus.rdata), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(60);
    check("ab_no_ack", 64'(ack_total - a0), 64'd0);

    // req dropped during WAIT on a read of slot 20
    a0 = ack_total;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_long = 1'b0;
    bus.req_addr = 5'd20; bus.req_wdata = 35'h0;
    tick(1);
    bus.req = 1'b0;
    bus.req_addr = 5'd3;
    check("dr_busy", 64'(bus.busy), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        got = 1'b1;
        break;
      end
    end
    tick(6);
    check("dr_ack_seen", 64'(got), 64'd1);
    check("dr_ack_once", 64'(ack_total - a0), 64'd1);
    check("dr_rdata",    64'(bus.rdata), 64'(exp_word(360, 17)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
